// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter slice.
//   - memory geometry (word-address and data widths)
//   - requester port indices (pipeline MEM stage, debug/program loader)
//   - starvation counter width
//   - dmem_req_t: one requester's {req, we, addr, wdata} bundle
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 10;
    localparam int DMEM_DATA_W  = 16;

    localparam int PORT_PIPE    = 0;
    localparam int PORT_DBG     = 1;

    localparam int STARVE_CNT_W = 4;

    typedef struct packed {
        logic                   req;
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: saturating count of consecutive denied port-1 cycles.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset (count -> 0)
//   inc_i     port 1 requested but was not granted this cycle
//   clr_i     port 1 granted, or not requesting; has priority over inc_i
//   at_max_o  count has reached STARVE_MAX (port 1 must be granted next)
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment and stick at MAX_C.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {STARVE_CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {STARVE_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline MEM
// stage (port 0, fixed priority) and the debug/program-loader port (port 1).
// Port 1 is forced a slot once it has been denied STARVE_MAX cycles in a row.
// Grants are combinational; read data is registered back to the winner.
// Ports:
//   Clk, Rst                       clock, synchronous active-high reset
//   req0/we0/addr0/wdata0          port-0 request bundle
//   gnt0, rvalid0, rdata0          port-0 grant (comb), read valid, read data
//   req1/we1/addr1/wdata1          port-1 request bundle
//   gnt1, rvalid1, rdata1          port-1 grant (comb), read valid, read data
//   mem_addr, mem_wdata            to memory; hold last granted values when idle
//   mem_read, mem_write            to memory MemRead / MemWrite
//   mem_rdata                      from memory (combinational read)
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_req_t         port_req_s [2];
    dmem_req_t         sel_s;
    logic [1:0]        gnt_s;
    logic              any_gnt_s;
    logic              force1_s;
    logic              rd_cap0_s;
    logic              rd_cap1_s;

    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign port_req_s[PORT_PIPE] = '{req: req0, we: we0, addr: addr0, wdata: wdata0};
    assign port_req_s[PORT_DBG]  = '{req: req1, we: we1, addr: addr1, wdata: wdata1};

    // Starvation tracking: every cycle port 1 waits while requesting counts up.
    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .inc_i    (req1 & ~gnt_s[PORT_DBG]),
        .clr_i    (gnt_s[PORT_DBG] | ~req1),
        .at_max_o (force1_s)
    );

    // Grant decision: forced port 1, else fixed priority port 0, else port 1.
    always_comb begin
        gnt_s = 2'b00;
        if (Rst) begin
            gnt_s = 2'b00;
        end else if (force1_s && req1) begin
            gnt_s[PORT_DBG] = 1'b1;
        end else if (req0) begin
            gnt_s[PORT_PIPE] = 1'b1;
        end else if (req1) begin
            gnt_s[PORT_DBG] = 1'b1;
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign any_gnt_s = gnt_s[PORT_PIPE] | gnt_s[PORT_DBG];

    // Select the winning request bundle.
    always_comb begin
        sel_s = port_req_s[PORT_PIPE];
        if (gnt_s[PORT_DBG]) begin
            sel_s = port_req_s[PORT_DBG];
        end else begin
            sel_s = port_req_s[PORT_PIPE];
        end
    end

    // Memory drive: idle cycles present the last granted address/data with
    // both strobes low so a wandering requester address cannot cause a write.
    always_comb begin
        mem_addr  = addr_hold_q;
        mem_wdata = wdata_hold_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (any_gnt_s) begin
            mem_addr  = sel_s.addr;
            mem_wdata = sel_s.wdata;
            mem_read  = ~sel_s.we;
            mem_write = sel_s.we;
        end else begin
            mem_addr  = addr_hold_q;
            mem_wdata = wdata_hold_q;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign rd_cap0_s = gnt_s[PORT_PIPE] & ~we0;
    assign rd_cap1_s = gnt_s[PORT_DBG]  & ~we1;

    // Held memory address/data and per-port read capture registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            addr_hold_q  <= {ADDR_W{1'b0}};
            wdata_hold_q <= {DATA_W{1'b0}};
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
        end else begin
            if (any_gnt_s) begin
                addr_hold_q  <= sel_s.addr;
                wdata_hold_q <= sel_s.wdata;
            end
            rvalid0_q <= rd_cap0_s;
            rvalid1_q <= rd_cap1_s;
            if (rd_cap0_s) begin
                rdata0_q <= mem_rdata;
            end
            if (rd_cap1_s) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign gnt0    = gnt_s[PORT_PIPE];
    assign gnt1    = gnt_s[PORT_DBG];
    // A reset arriving in the valid cycle discards the read immediately.
    assign rvalid0 = rvalid0_q & ~Rst;
    assign rvalid1 = rvalid1_q & ~Rst;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven bench for dmem_arbiter with a
// behavioural single-port memory (combinational read, write on rising edge).
module tb_dmem_arbiter;

    logic        Clk;
    logic        Rst;
    logic        req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:1023];

    int total;
    int bad;

    dmem_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (16),
        .STARVE_MAX (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge Clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [9:0]  a0;
        logic [15:0] d0;
        logic        r1;
        logic        w1;
        logic [9:0]  a1;
        logic [15:0] d1;
        logic        e_g0;
        logic        e_g1;
        logic        e_rd;
        logic        e_wr;
        logic [9:0]  e_maddr;
        logic        e_rv0;
        logic [15:0] e_rdata0;
        logic        e_rv1;
        logic [15:0] e_rdata1;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic w0,
                         input logic [9:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1,
                         input logic [9:0] a1, input logic [15:0] d1);
        Rst = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    initial begin
        int first_g1;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h3FF] = 16'h5A5A;

        // Reset, both ports requesting
        for (int i = 0; i < 3; i++)
            vecs[i] = '{1'b1, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b1, 1'b0, 10'h007, 16'h0000,
                        1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        // Port 0 write 0x1234 -> 0x005, then read it back
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 10'h007, 16'h0000,
                     1'b1, 1'b0, 1'b0, 1'b1, 10'h005, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h007, 16'h0000,
                     1'b1, 1'b0, 1'b1, 1'b0, 10'h005, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h007, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h005, 1'b1, 16'h1234, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h007, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h005, 1'b0, 16'h1234, 1'b0, 16'h0000};
        // Contention: port 0 writes every cycle, port 1 reads 0x005
        for (int i = 7; i < 11; i++)
            vecs[i] = '{1'b0, 1'b1, 1'b1, 10'h020, 16'h0A0A, 1'b1, 1'b0, 10'h005, 16'h0000,
                        1'b1, 1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 16'h1234, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 10'h020, 16'h0A0A, 1'b1, 1'b0, 10'h005, 16'h0000,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h005, 1'b0, 16'h1234, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 10'h020, 16'h0A0A, 1'b0, 1'b0, 10'h005, 16'h0000,
                     1'b1, 1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 16'h1234, 1'b1, 16'h1234};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0A0A, 1'b0, 1'b0, 10'h005, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h020, 1'b0, 16'h1234, 1'b0, 16'h1234};
        // Port 1 alone reads 0x3FF
        vecs[14] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b0, 10'h3FF, 16'h0000,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0, 16'h1234, 1'b0, 16'h1234};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b0, 10'h3FF, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b0, 16'h1234, 1'b1, 16'h5A5A};
        // Port 1 write 0xBEEF -> 0x010, then idle with addr1 moved to 0x011
        vecs[16] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b1, 10'h010, 16'hBEEF,
                     1'b0, 1'b1, 1'b0, 1'b1, 10'h010, 1'b0, 16'h1234, 1'b0, 16'h5A5A};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b1, 10'h011, 16'h1111,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h010, 1'b0, 16'h1234, 1'b0, 16'h5A5A};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b0, 10'h010, 16'h0000,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h010, 1'b0, 16'h1234, 1'b0, 16'h5A5A};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b0, 10'h010, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h010, 1'b0, 16'h1234, 1'b1, 16'hBEEF};

        drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
        @(posedge Clk); #1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge Clk);
            chk($sformatf("v%0d.gnt0", i),      32'(gnt0),      32'(vecs[i].e_g0));
            chk($sformatf("v%0d.gnt1", i),      32'(gnt1),      32'(vecs[i].e_g1));
            chk($sformatf("v%0d.mem_read", i),  32'(mem_read),  32'(vecs[i].e_rd));
            chk($sformatf("v%0d.mem_write", i), 32'(mem_write), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d.mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_maddr));
            chk($sformatf("v%0d.rvalid0", i),   32'(rvalid0),   32'(vecs[i].e_rv0));
            chk($sformatf("v%0d.rdata0", i),    32'(rdata0),    32'(vecs[i].e_rdata0));
            chk($sformatf("v%0d.rvalid1", i),   32'(rvalid1),   32'(vecs[i].e_rv1));
            chk($sformatf("v%0d.rdata1", i),    32'(rdata1),    32'(vecs[i].e_rdata1));
            @(posedge Clk); #1;
        end

        chk("mem[0x010]", 32'(mem[10'h010]), 32'h0000BEEF);
        chk("mem[0x011]", 32'(mem[10'h011]), 32'h00000000);
        chk("mem[0x020]", 32'(mem[10'h020]), 32'h00000A0A);
        chk("mem[0x005]", 32'(mem[10'h005]), 32'h00001234);

        // Reset mid-read: build up two denied port-1 cycles, read on port 0,
        // then assert Rst in the rvalid cycle.
        drive(1'b0, 1'b1, 1'b1, 10'h020, 16'h0A0A, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        @(negedge Clk);
        chk("mr.pre_gnt0", 32'(gnt0), 32'd1);
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        @(negedge Clk);
        chk("mr.read_gnt0", 32'(gnt0), 32'd1);
        chk("mr.read_mem_read", 32'(mem_read), 32'd1);
        @(posedge Clk); #1;
        drive(1'b1, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        @(negedge Clk);
        chk("mr.rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("mr.rst_gnt0", 32'(gnt0), 32'd0);
        chk("mr.rst_gnt1", 32'(gnt1), 32'd0);
        chk("mr.rst_mem_read", 32'(mem_read), 32'd0);
        @(posedge Clk); #1;

        // After reset the starvation count must restart from zero: with both
        // ports requesting, port 1 gets its first grant in cycle 4.
        drive(1'b0, 1'b1, 1'b1, 10'h020, 16'h0A0A, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        first_g1 = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (k == 0) chk("mr.post_rvalid0", 32'(rvalid0), 32'd0);
            if (gnt1) begin
                first_g1 = k;
                chk("mr.force_gnt0_low", 32'(gnt0), 32'd0);
                break;
            end
            @(posedge Clk); #1;
        end
        chk("mr.first_gnt1_cycle", 32'(first_g1), 32'd4);
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b1, 10'h020, 16'h0A0A, 1'b0, 1'b0, 10'h3FF, 16'h0000);
        @(negedge Clk);
        chk("mr.gnt0_resumes", 32'(gnt0), 32'd1);
        chk("mr.rvalid1_after_force", 32'(rvalid1), 32'd1);
        chk("mr.rdata1_after_force", 32'(rdata1), 32'h00005A5A);
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port 16-bit data memory between the pipeline MEM stage (port 0) and the debug/program-loader port (port 1). It sits between those requesters and the data memory, drives the memory's address, write-data, MemRead and MemWrite inputs, and registers the read data back to the winning requester. Port 0 has fixed priority. A starvation counter guarantees port 1 a slot after a bounded wait. While port 1 holds the memory, the pipeline is stalled through `gnt0` low.

## Interface
- `ADDR_W`, 10: memory word-address width
- `DATA_W`, 16: memory data width
- `STARVE_MAX`, 4: number of consecutive denied port-1 cycles before port 1 is forced a grant (1..15)

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `req0`, `we0`  in  1  port-0 request / write-enable (0 = read)
- `addr0`  in  ADDR_W  port-0 address
- `wdata0`  in  DATA_W  port-0 write data
- `gnt0`  out  1  port-0 granted this cycle (combinational)
- `rvalid0`  out  1  port-0 read data valid
- `rdata0`  out  DATA_W  port-0 read data
- `req1`, `we1`, `addr1`, `wdata1`, `gnt1`, `rvalid1`, `rdata1`: same for port 1
- `mem_addr`  out  ADDR_W  to memory Address
- `mem_wdata`  out  DATA_W  to memory Write_Data
- `mem_read`, `mem_write`  out  1  to memory MemRead / MemWrite
- `mem_rdata`  in  DATA_W  from memory Read_Data (combinational read)

## Operation
- At most one grant per cycle. `gnt0 & gnt1` is never 1.
- Grant rule:
  - if `force1`, grant goes to port 1 when `req1`=1;
  - else port 0 wins when `req0`=1;
  - else port 1 wins when `req1`=1.
- `force1` = (`starve_cnt` == `STARVE_MAX`).
- `starve_cnt` (4 bits) updates per cycle:
  - +1 when `req1` & !`gnt1` (saturates at `STARVE_MAX`);
  - cleared when `gnt1`;
  - cleared when `req1`=0.
- Memory outputs follow the granted port's addr/wdata. `mem_read` = grant & !we; `mem_write` = grant & we.
- With no grant, `mem_read`=`mem_write`=0, and `mem_addr`/`mem_wdata` hold the last granted values. This keeps the memory from rewriting on address glitches.
- Read capture:
  - on a granted read, `mem_rdata` is registered into the granted port's `rdata` at the clock edge, and its `rvalid` is 1 for exactly the next cycle;
  - `rdata` holds its value until the next read by that port.
- Writes produce no `rvalid`.
- Requester rule: when `req` is high with `gnt` low, the requester holds `req`, `we`, `addr` and `wdata` stable until the cycle `gnt` is high. A request is consumed in its `gnt` cycle.
- Back-to-back grants to either port are allowed every cycle. Throughput is one access per cycle.

## Timing
- Grant latency: combinational, same cycle as `req` when that port wins.
- Read latency: `gnt` in cycle N, then `rvalid`/`rdata` in cycle N+1.
- Write: memory written in the `gnt` cycle N.
- Reset values: `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0, `starve_cnt`=0, held `mem_addr`/`mem_wdata`=0.
- While `Rst`=1: `gnt0`=`gnt1`=0 and `mem_read`=`mem_write`=0.
- Reset mid-read: if `Rst` is asserted in cycle N+1 of a read, `rvalid` is forced 0 from cycle N+1 onward and the read is discarded.
- Simultaneous `req0`/`req1` with `starve_cnt`<`STARVE_MAX`: port 0 wins and the counter increments.
- Worst case: port 1 is granted no later than `STARVE_MAX`+1 cycles after raising `req1`.

## Structure
- Shared package `dmem_pkg`:
  - `DMEM_ADDR_W`=10, `DMEM_DATA_W`=16;
  - port index constants `PORT_PIPE`=0, `PORT_DBG`=1;
  - `dmem_req_t` struct {req, we, addr, wdata}.
- Sub-module `dmem_starve_ctr`: saturating counter with inputs inc/clr and output `at_max`. The top level contains grant logic, output muxing and read-capture registers.

## Test plan
- Reset: hold `Rst` 3 cycles with `req0`=`req1`=1. Required: all `gnt`, `mem_read`, `mem_write`, `rvalid` = 0; `rdata` = 0.
- Port-0 read: write 0x1234 to addr 0x005 via port 0, then read addr 0x005. Required: `gnt0` in the same cycle as `req0`; `rvalid0`=1 with `rdata0`=0x1234 exactly one cycle later; `rvalid1` stays 0.
- Contention: `req0` held continuously, `req1` raised at cycle 0 with `STARVE_MAX`=4. Required: `gnt1`=1 only in cycle 4, `gnt0`=0 in that cycle, then `gnt0` resumes in cycle 5.
- Idle port 0: `req1` alone, read addr 0x3FF. Required: `gnt1` same cycle, `mem_addr`=0x3FF, `rdata1` valid next cycle.
- Write hold: port-1 write of 0xBEEF to 0x010, followed by an idle cycle with `addr1` changed to 0x011. Required: `mem_write`=0 in the idle cycle and location 0x011 unchanged.
- Reset mid-read: `Rst` asserted in the `rvalid` cycle. Required: `rvalid0`=0 that cycle and `starve_cnt`=0 afterwards.
